// File: rtl/if_imem_ctrl.sv
// if_imem_ctrl -- instruction-fetch memory controller
//
// Holds a DEPTH-word instruction memory that is loaded through a separate
// write port. It serves one fetch at a time through a valid/ready request
// channel and a valid/ready response channel. The response becomes visible
// 1 + WAIT_STATES cycles after the accept edge. Misaligned fetches and
// out-of-range fetches return a NOP with the fault flag set. A flush (branch
// redirect) drops the fetch that is in flight.
//
// Ports
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_flush      : drop the in-flight fetch / block acceptance this cycle
//   i_req_valid  : fetch request valid
//   o_req_ready  : fetch request can be accepted this cycle
//   i_req_addr   : fetch byte address
//   o_rsp_valid  : response valid (high only while a response is presented)
//   i_rsp_ready  : consumer takes the response
//   o_instr      : fetched instruction (holds the last response when idle)
//   o_rsp_fault  : response is a fault (misaligned or out of range)
//   i_ld_en      : program-load write strobe
//   i_ld_addr    : program-load byte address
//   i_ld_data    : program-load data word
module if_imem_ctrl #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH       = 64,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter int unsigned     WAIT_STATES = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [XLEN-1:0] i_req_addr,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_instr,
  output logic            o_rsp_fault,
  input  logic            i_ld_en,
  input  logic [XLEN-1:0] i_ld_addr,
  input  logic [XLEN-1:0] i_ld_data
);

  localparam int unsigned     IW  = $clog2(DEPTH);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // The counter counts down to zero, so it is preloaded with one less than
  // the number of extra cycles.
  localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  // Word offset from the base: this equals (a - BASE_ADDR) >> 2 modulo 2^XLEN.
  // It works on the upper bits only and subtracts a borrow when the low two
  // bits of the address are below those of the base.
  function automatic logic [XLEN-3:0] word_off(input logic [XLEN-1:0] a);
    return a[XLEN-1:2] - BASE_ADDR[XLEN-1:2]
           - (XLEN-2)'(a[1:0] < BASE_ADDR[1:0]);
  endfunction

  // Any bit set above the index field means the offset is beyond DEPTH.
  // Addresses below the base wrap to huge offsets and land here too.
  function automatic logic addr_fault(input logic [XLEN-1:0] a,
                                      input logic [XLEN-3:0] woff);
    return (a[1:0] != 2'b00) || (|woff[XLEN-3:IW]);
  endfunction

  logic [1:0]      r_state;
  logic [2:0]      r_cnt;
  logic [XLEN-1:0] r_instr;
  logic            r_fault;

  // Memory contents start as NOP and are deliberately left out of the reset.
  logic [XLEN-1:0] r_mem [DEPTH] = '{default: NOP};

  logic [XLEN-3:0] w_req_woff;
  logic [XLEN-3:0] w_ld_woff;
  logic            w_req_fault;
  logic            w_ld_fault;
  logic [IW-1:0]   w_req_idx;
  logic [IW-1:0]   w_ld_idx;
  logic            w_accept;

  assign w_req_woff  = word_off(i_req_addr);
  assign w_ld_woff   = word_off(i_ld_addr);
  assign w_req_fault = addr_fault(i_req_addr, w_req_woff);
  assign w_ld_fault  = addr_fault(i_ld_addr, w_ld_woff);
  assign w_req_idx   = w_req_woff[IW-1:0];
  assign w_ld_idx    = w_ld_woff[IW-1:0];

  // i_rst_n gates ready directly so that ready is low for the whole reset
  // pulse, even before the state register has been cleared.
  assign o_req_ready = i_rst_n && (r_state == S_IDLE) && !i_ld_en && !i_flush;
  assign w_accept    = i_req_valid && o_req_ready;

  assign o_rsp_valid = (r_state == S_RESP);
  assign o_instr     = r_instr;
  assign o_rsp_fault = r_fault;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_instr <= NOP;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // The memory is read before any load at this same edge, so the
            // response is captured once and is unaffected by later loads.
            r_instr <= w_req_fault ? NOP : r_mem[w_req_idx];
            r_fault <= w_req_fault;
            if (WAIT_STATES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (i_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
          end else if (r_cnt == 3'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_RESP: begin
          // A flush takes priority over a handshake. Both cases go back to
          // IDLE, and the response counts as dropped when a flush is present.
          if (i_flush || i_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The program-load port writes in every FSM state. Faulting addresses are
  // dropped so that they cannot alias onto a valid word.
  always_ff @(posedge i_clk) begin
    if (i_ld_en && !w_ld_fault) begin
      r_mem[w_ld_idx] <= i_ld_data;
    end
  end

endmodule

// File: tb/tb_if_imem_ctrl.sv
// Testbench for if_imem_ctrl. Three instances with different wait states and
// base addresses are checked every cycle against a transaction-level model.
module tb_if_imem_ctrl;

  localparam int          N     = 3;
  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          WS_K   [N] = '{0, 2, 3};
  localparam logic [31:0] BASE_K [N] = '{32'h0, 32'h100, 32'h0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush     [N];
  logic        req_valid [N];
  logic        rsp_ready [N];
  logic        ld_en     [N];
  logic [31:0] req_addr  [N];
  logic [31:0] ld_addr   [N];
  logic [31:0] ld_data   [N];
  logic        req_ready [N];
  logic        rsp_valid [N];
  logic        rsp_fault [N];
  logic [31:0] instr     [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    if_imem_ctrl #(
      .XLEN(32), .DEPTH(DEPTH), .BASE_ADDR(BASE_K[g]), .WAIT_STATES(WS_K[g])
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush[g]),
      .i_req_valid(req_valid[g]), .o_req_ready(req_ready[g]),
      .i_req_addr(req_addr[g]), .o_rsp_valid(rsp_valid[g]),
      .i_rsp_ready(rsp_ready[g]), .o_instr(instr[g]),
      .o_rsp_fault(rsp_fault[g]), .i_ld_en(ld_en[g]),
      .i_ld_addr(ld_addr[g]), .i_ld_data(ld_data[g])
    );
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: one outstanding fetch per instance, stamped with its accept cycle.
  bit          busy_m  [N];
  int          acc_cyc [N];
  logic [31:0] instr_m [N];
  logic        fault_m [N];
  logic [31:0] mem_m   [N][DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_fault(int k, logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_K[k];
    return (a % 4 != 0) || ((off / 4) >= DEPTH);
  endfunction

  function automatic int m_idx(int k, logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_K[k];
    return int'(off / 4);
  endfunction

  function automatic bit m_valid(int k);
    return busy_m[k] && (cyc - acc_cyc[k] >= 1 + WS_K[k]);
  endfunction

  function automatic bit m_ready(int k);
    return rst_n && !busy_m[k] && !ld_en[k] && !flush[k];
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < N; k++) begin
      busy_m[k]  = 1'b0;
      instr_m[k] = NOP;
      fault_m[k] = 1'b0;
    end
  endfunction

  function automatic void m_edge();
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        busy_m[k]  = 1'b0;
        instr_m[k] = NOP;
        fault_m[k] = 1'b0;
      end else if (busy_m[k]) begin
        if (flush[k]) busy_m[k] = 1'b0;
        else if (m_valid(k) && rsp_ready[k]) busy_m[k] = 1'b0;
      end else if (req_valid[k] && m_ready(k)) begin
        busy_m[k]  = 1'b1;
        acc_cyc[k] = cyc;
        fault_m[k] = m_fault(k, req_addr[k]);
        instr_m[k] = fault_m[k] ? NOP : mem_m[k][m_idx(k, req_addr[k])];
      end
      if (ld_en[k] && !m_fault(k, ld_addr[k]))
        mem_m[k][m_idx(k, ld_addr[k])] = ld_data[k];
    end
    cyc++;
  endfunction

  task automatic idle_all();
    for (int k = 0; k < N; k++) begin
      flush[k] = 0; req_valid[k] = 0; rsp_ready[k] = 0; ld_en[k] = 0;
      req_addr[k] = 0; ld_addr[k] = 0; ld_data[k] = 0;
    end
  endtask

  // Inputs are set before the call (just after a rising edge). Outputs are
  // compared on the falling edge, then the model advances across the edge.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("valid%0d", k), rsp_valid[k], m_valid(k));
      chk($sformatf("ready%0d", k), req_ready[k], m_ready(k));
      chk($sformatf("instr%0d", k), instr[k], instr_m[k]);
      chk($sformatf("fault%0d", k), rsp_fault[k], fault_m[k]);
    end
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input logic [31:0] a, input logic [31:0] d);
    ld_en[k] = 1; ld_addr[k] = a; ld_data[k] = d;
    step();
    ld_en[k] = 0;
  endtask

  // Issue a fetch and return the cycles from accept edge to visible valid.
  task automatic fetch(input int k, input logic [31:0] a, output int lat);
    int n;
    req_valid[k] = 1; req_addr[k] = a; rsp_ready[k] = 0;
    step();
    req_valid[k] = 0;
    n = 0;
    while (!rsp_valid[k] && n < 12) begin
      step();
      n++;
    end
    lat = n + 1;
  endtask

  task automatic consume(input int k);
    rsp_ready[k] = 1;
    step();
    rsp_ready[k] = 0;
  endtask

  function automatic logic [31:0] rand_addr(int k);
    int          r;
    logic [31:0] a;
    r = $urandom_range(0, 15);
    a = BASE_K[k] + 32'(4 * $urandom_range(0, DEPTH + 1));
    if (r == 0) a = a + 32'($urandom_range(1, 3));
    else if (r == 1) a = BASE_K[k] - 32'(4 * $urandom_range(1, 2));
    return a;
  endfunction

  initial begin
    int lat;
    rst_n = 0;
    idle_all();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < DEPTH; i++) mem_m[k][i] = NOP;
    m_reset();
    repeat (3) step();
    rst_n = 1;
    step();

    // Load, then fetch with zero wait states.
    load(0, 32'h0, 32'h0010_0093);
    req_valid[0] = 1; req_addr[0] = 32'h0; rsp_ready[0] = 1;
    step();
    req_valid[0] = 0;
    chk("t1_valid", rsp_valid[0], 1);
    chk("t1_instr", instr[0], 32'h0010_0093);
    chk("t1_fault", rsp_fault[0], 0);
    step();
    rsp_ready[0] = 0;
    chk("t1_done", rsp_valid[0], 0);

    // Three wait states: latency, then a held response under backpressure.
    load(2, 32'h8, 32'hA5A5_0001);
    fetch(2, 32'h8, lat);
    chk("t2_lat", lat, 4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_v", rsp_valid[2], 1);
      chk("t2_hold_i", instr[2], 32'hA5A5_0001);
      chk("t2_hold_r", req_ready[2], 0);
    end
    consume(2);

    // Faulting fetches, and a load to an out-of-range address.
    fetch(0, 32'h6, lat);
    chk("t3_mis_f", rsp_fault[0], 1);
    chk("t3_mis_i", instr[0], NOP);
    consume(0);
    fetch(0, 32'(4 * DEPTH), lat);
    chk("t3_oor_f", rsp_fault[0], 1);
    chk("t3_oor_i", instr[0], NOP);
    consume(0);
    load(0, 32'(4 * DEPTH), 32'hDEAD_BEEF);
    fetch(0, 32'h0, lat);
    chk("t3_alias", instr[0], 32'h0010_0093);
    chk("t3_ok_f", rsp_fault[0], 0);
    consume(0);
    fetch(1, 32'hFC, lat);
    chk("t3_below", rsp_fault[1], 1);
    consume(1);

    // Flush in WAIT, and flush together with ready in RESP.
    req_valid[1] = 1; req_addr[1] = 32'h104; rsp_ready[1] = 0;
    step();
    req_valid[1] = 0; flush[1] = 1;
    step();
    flush[1] = 0;
    #1;
    chk("t4_ready", req_ready[1], 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_novalid", rsp_valid[1], 0);
    end
    fetch(1, 32'h108, lat);
    chk("t4_lat", lat, 3);
    flush[1] = 1; rsp_ready[1] = 1;
    step();
    flush[1] = 0; rsp_ready[1] = 0;
    chk("t4_drop", rsp_valid[1], 0);
    #1;
    chk("t4_ready2", req_ready[1], 1);

    // A load during WAIT leaves the captured response alone.
    load(2, 32'hC, 32'h1111_1111);
    req_valid[2] = 1; req_addr[2] = 32'hC;
    step();
    req_valid[2] = 0;
    load(2, 32'hC, 32'h2222_2222);
    for (int i = 0; i < 8 && !rsp_valid[2]; i++) step();
    chk("t5_old_v", rsp_valid[2], 1);
    chk("t5_old", instr[2], 32'h1111_1111);
    consume(2);
    fetch(2, 32'hC, lat);
    chk("t5_new", instr[2], 32'h2222_2222);
    consume(2);

    // Asynchronous reset between edges while a faulted response is held.
    fetch(0, 32'h6, lat);
    chk("t6_pre_f", rsp_fault[0], 1);
    #2;
    rst_n = 0;
    #1;
    m_reset();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("t6_valid%0d", k), rsp_valid[k], 0);
      chk($sformatf("t6_instr%0d", k), instr[k], NOP);
      chk($sformatf("t6_fault%0d", k), rsp_fault[k], 0);
      chk($sformatf("t6_ready%0d", k), req_ready[k], 0);
    end
    step();
    rst_n = 1;
    step();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        req_valid[k] = ($urandom_range(0, 2) != 0);
        req_addr[k]  = rand_addr(k);
        flush[k]     = ($urandom_range(0, 15) == 0);
        rsp_ready[k] = $urandom_range(0, 1) == 1;
        ld_en[k]     = ($urandom_range(0, 7) == 0);
        ld_addr[k]   = rand_addr(k);
        ld_data[k]   = $urandom;
      end
      step();
    end
    idle_all();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_imem_ctrl.md
IF_IMEM_CTRL -- requirements
Module: if_imem_ctrl

Interface
REQ-001 SHALL have parameter XLEN, 32, instruction/address width in bits.
REQ-002 SHALL have parameter DEPTH, 64, memory depth in XLEN-bit words (power of two, 4..4096).
REQ-003 SHALL have parameter BASE_ADDR, 0, byte address of word 0.
REQ-004 SHALL have parameter WAIT_STATES, 0, extra response latency in cycles (0..7).
REQ-005 SHALL have port i_clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port i_flush  input  1  discard in-flight fetch (branch redirect).
REQ-008 SHALL have port i_req_valid  input  1  fetch request valid.
REQ-009 SHALL have port o_req_ready  output  1  fetch request accepted when valid and ready.
REQ-010 SHALL have port i_req_addr  input  XLEN  fetch byte address.
REQ-011 SHALL have port o_rsp_valid  output  1  response valid.
REQ-012 SHALL have port i_rsp_ready  input  1  consumer takes response.
REQ-013 SHALL have port o_instr  output  XLEN  fetched instruction.
REQ-014 SHALL have port o_rsp_fault  output  1  response is a fault (misaligned/out of range).
REQ-015 SHALL have port i_ld_en  input  1  program-load write strobe.
REQ-016 SHALL have port i_ld_addr  input  XLEN  program-load byte address.
REQ-017 SHALL have port i_ld_data  input  XLEN  program-load data.

Function
REQ-018 SHALL store DEPTH words; index = (addr - BASE_ADDR) >> 2, modulo-XLEN subtraction.
REQ-019 SHALL treat an address as faulting if addr[1:0] != 0 or index >= DEPTH (including wrap below BASE_ADDR).
REQ-020 SHALL implement FSM IDLE, WAIT, RESP; o_req_ready = 1 only in IDLE with i_ld_en = 0 and i_flush = 0.
REQ-021 On accept in IDLE SHALL capture mem[index] (or NOP 32'h00000013 plus fault flag if faulting) into the response register at that edge.
REQ-022 After accept SHALL go to RESP if WAIT_STATES = 0, else WAIT; WAIT loads counter with WAIT_STATES-1, decrements each cycle, goes to RESP when counter = 0.
REQ-023 Latency: o_rsp_valid rises exactly 1 + WAIT_STATES cycles after the accept edge.
REQ-024 In RESP SHALL hold o_rsp_valid, o_instr, o_rsp_fault stable until i_rsp_ready = 1, then return to IDLE next edge; no new request accepted in the same cycle.
REQ-025 o_rsp_valid SHALL be 0 outside RESP; o_instr/o_rsp_fault hold last response value outside RESP.
REQ-026 i_flush = 1 in WAIT or RESP SHALL return FSM to IDLE at next edge with no response delivered; flush and i_rsp_ready together in RESP: flush wins (response treated as dropped).
REQ-027 i_flush in IDLE SHALL block acceptance that cycle and otherwise have no effect.
REQ-028 i_ld_en = 1 SHALL write i_ld_data to mem[index of i_ld_addr] at the edge in any FSM state; faulting load addresses SHALL be ignored.
REQ-029 A load during WAIT/RESP SHALL NOT alter the already-captured response.
REQ-030 Memory contents SHALL initialise to NOP at time zero and SHALL NOT be affected by reset.

Reset
REQ-031 i_rst_n = 0 SHALL immediately force IDLE, counter 0, o_rsp_valid 0, o_rsp_fault 0, o_instr 32'h00000013, regardless of clock.
REQ-032 Reset mid-fetch SHALL drop the fetch; after release first accept occurs no earlier than the first rising edge with i_rst_n = 1.
REQ-033 o_req_ready SHALL be 0 while i_rst_n = 0.

Verification
REQ-034 WAIT_STATES=0: load 0x00100093 at addr 0, fetch addr 0 with i_rsp_ready=1 -> o_rsp_valid one cycle after accept, o_instr=0x00100093, fault 0.
REQ-035 WAIT_STATES=3: fetch addr 8 -> o_rsp_valid exactly 4 cycles after accept; hold i_rsp_ready=0 for 5 cycles -> outputs stable, o_req_ready 0 throughout.
REQ-036 Fetch addr 6 and addr 4*DEPTH -> o_rsp_fault=1, o_instr=0x00000013; load to addr 4*DEPTH leaves memory unchanged.
REQ-037 WAIT_STATES=2: flush one cycle after accept -> no o_rsp_valid pulse, o_req_ready 1 next cycle; flush with i_rsp_ready in RESP -> response dropped.
REQ-038 Load addr 12 with new data during WAIT of fetch to addr 12 -> response carries old data; refetch returns new data.
REQ-039 Assert i_rst_n=0 between edges during RESP -> o_rsp_valid 0 immediately, o_instr 0x00000013.
